// File: rtl/dffsre_ctrl_pkg.sv
// Shared types for the dffsre bank control path.
// Holds the command opcode encoding, the sequencer state encoding and
// an index-width helper used by the arbiter and its round-robin picker.
package dffsre_ctrl_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD = 2'b00,
        OP_SET  = 2'b01,
        OP_CLR  = 2'b10,
        OP_RSV  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    // Bits needed to hold an index into n entries (never less than one).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dffsre_bank_arbiter_if.sv
// Request/command/result bundle between control masters and the bank arbiter.
// Ports (master view):
//   req   [NREQ]        out  per-requester level request, held until ack
//   op    [2*NREQ]      out  per-requester opcode (LOAD/SET/CLEAR/reserved)
//   wdata [NBITS*NREQ]  out  per-requester LOAD data
//   wmask [NBITS*NREQ]  out  per-requester bit mask
//   sel                 out  output gate for Q_out
//   ack   [NREQ]        in   one-cycle completion pulse, one-hot or zero
//   err                 in   pulses with ack when the served op was reserved
//   busy                in   sequencer is not idle
//   Q     [NBITS]       in   bank contents
//   Q_out [NBITS]       in   sel-gated copy of Q
interface dffsre_bank_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NBITS = 8
);
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     op;
    logic [NBITS*NREQ-1:0] wdata;
    logic [NBITS*NREQ-1:0] wmask;
    logic                  sel;
    logic [NREQ-1:0]       ack;
    logic                  err;
    logic                  busy;
    logic [NBITS-1:0]      Q;
    logic [NBITS-1:0]      Q_out;

    modport master (
        output req, op, wdata, wmask, sel,
        input  ack, err, busy, Q, Q_out
    );

    modport slave (
        input  req, op, wdata, wmask, sel,
        output ack, err, busy, Q, Q_out
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N.
// Ports:
//   req   [N]   in   request vector
//   ptr   [IW]  in   highest-priority position
//   grant [N]   out  one-hot grant (zero when no request)
//   idx   [IW]  out  index of the granted request
//   valid       out  at least one request present
module rr_pick
    import dffsre_ctrl_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] k;

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        k     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k = IW'((32'(ptr) + i) % N);
            if (!valid && req[k]) begin
                grant[k] = 1'b1;
                idx      = k;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dffsre_bank_arbiter.sv
// Round-robin arbiter and sequencer sharing a bank of NBITS enable/set/reset
// flops between NREQ requesters issuing masked LOAD/SET/CLEAR commands.
// Ports:
//   C    in  clock, rising edge
//   R    in  synchronous active-high reset
//   bus  slave side of dffsre_bank_arbiter_if (req/op/wdata/wmask/sel in,
//        ack/err/busy/Q/Q_out out; Q_out is combinational sel ? Q : 0)
module dffsre_bank_arbiter
    import dffsre_ctrl_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NBITS = 8
) (
    input  logic                 C,
    input  logic                 R,
    dffsre_bank_arbiter_if.slave bus
);

    localparam int unsigned IW = idx_width(NREQ);

    state_e            state_q;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     idx_q;
    logic [NREQ-1:0]   gnt_q;
    op_e               op_q;
    logic [NBITS-1:0]  wdata_q;
    logic [NBITS-1:0]  wmask_q;
    logic [NBITS-1:0]  bank_q;
    logic [NREQ-1:0]   ack_q;
    logic              err_q;
    logic              busy_q;

    logic [NREQ-1:0]   gnt;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_valid;

    logic [OP_W-1:0]   op_arr    [NREQ];
    logic [NBITS-1:0]  wdata_arr [NREQ];
    logic [NBITS-1:0]  wmask_arr [NREQ];

    // Split the flattened per-requester fields so they can be indexed by grant.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_arr[g]    = bus.op[OP_W*g +: OP_W];
        assign wdata_arr[g] = bus.wdata[NBITS*g +: NBITS];
        assign wmask_arr[g] = bus.wmask[NBITS*g +: NBITS];
    end

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .grant (gnt),
        .idx   (gnt_idx),
        .valid (gnt_valid)
    );

    // Masked bank update; unmasked bits and the reserved opcode hold.
    function automatic logic [NBITS-1:0] next_bank(
        input logic [NBITS-1:0] q,
        input logic [NBITS-1:0] d,
        input logic [NBITS-1:0] m,
        input op_e              o
    );
        case (o)
            OP_LOAD: return (q & ~m) | (d & m);
            OP_SET:  return q | m;
            OP_CLR:  return q & ~m;
            default: return q;
        endcase
    endfunction

    // Sequencer: latch a winner in IDLE, update the bank in APPLY, pulse ack in ACK.
    always_ff @(posedge C) begin
        if (R) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            op_q    <= OP_LOAD;
            wdata_q <= '0;
            wmask_q <= '0;
            bank_q  <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= '0;
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        idx_q   <= gnt_idx;
                        gnt_q   <= gnt;
                        op_q    <= op_e'(op_arr[gnt_idx]);
                        wdata_q <= wdata_arr[gnt_idx];
                        wmask_q <= wmask_arr[gnt_idx];
                        state_q <= ST_APPLY;
                        busy_q  <= 1'b1;
                    end
                end
                ST_APPLY: begin
                    bank_q  <= next_bank(bank_q, wdata_q, wmask_q, op_q);
                    state_q <= ST_ACK;
                end
                ST_ACK: begin
                    ack_q   <= gnt_q;
                    err_q   <= (op_q == OP_RSV);
                    // Served requester drops to lowest priority.
                    ptr_q   <= (32'(idx_q) == NREQ - 1) ? '0 : idx_q + 1'b1;
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;
    assign bus.Q     = bank_q;
    assign bus.Q_out = bus.sel ? bank_q : '0;

endmodule

// File: tb/tb_dffsre_bank_arbiter.sv
// Bench for dffsre_bank_arbiter: transaction-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_dffsre_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int NBITS = 8;

    logic C = 1'b0;
    logic R = 1'b1;

    dffsre_bank_arbiter_if #(.NREQ(NREQ), .NBITS(NBITS)) bus ();

    dffsre_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS)) dut (
        .C   (C),
        .R   (R),
        .bus (bus)
    );

    always #5 C = ~C;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one transaction occupies 3 cycles; bank changes after the 2nd edge,
    // ack is visible after the 3rd.
    logic [NBITS-1:0] m_q   = '0;
    logic [NBITS-1:0] m_d   = '0;
    logic [NBITS-1:0] m_m   = '0;
    logic [NREQ-1:0]  m_ack = '0;
    logic [1:0]       m_op  = '0;
    logic             m_err = 1'b0;
    int               m_ptr = 0;
    int               m_cnt = 0;
    int               m_idx = 0;
    bit               m_live = 1'b0;
    int               cyc = 0;

    always @(posedge C) begin
        cyc++;
        m_live = 1'b1;
        if (R) begin
            m_q = '0; m_ptr = 0; m_cnt = 0; m_ack = '0; m_err = 1'b0;
        end else begin
            m_ack = '0;
            m_err = 1'b0;
            if (m_cnt == 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (m_cnt == 0 && bus.req[(m_ptr + k) % NREQ]) begin
                        m_idx = (m_ptr + k) % NREQ;
                        m_op  = bus.op[2*m_idx +: 2];
                        m_d   = bus.wdata[NBITS*m_idx +: NBITS];
                        m_m   = bus.wmask[NBITS*m_idx +: NBITS];
                        m_cnt = 2;
                    end
                end
            end else if (m_cnt == 2) begin
                for (int b = 0; b < NBITS; b++) begin
                    if (m_m[b]) begin
                        case (m_op)
                            2'd0: m_q[b] = m_d[b];
                            2'd1: m_q[b] = 1'b1;
                            2'd2: m_q[b] = 1'b0;
                            default: ;
                        endcase
                    end
                end
                m_cnt = 1;
            end else begin
                m_ack[m_idx] = 1'b1;
                m_err = (m_op == 2'd3);
                m_ptr = (m_idx + 1) % NREQ;
                m_cnt = 0;
            end
        end
    end

    // Per-cycle comparison against the model, plus ack history.
    int ack_log[$];
    int ack_cyc[$];

    always @(negedge C) begin
        if (m_live) begin
            chk("Q",      32'(bus.Q),     32'(m_q));
            chk("Q_out",  32'(bus.Q_out), 32'(bus.sel ? m_q : {NBITS{1'b0}}));
            chk("ack",    32'(bus.ack),   32'(m_ack));
            chk("err",    32'(bus.err),   32'(m_err));
            chk("busy",   32'(bus.busy),  32'(m_cnt != 0));
            chk("ack_onehot", 32'($onehot0(bus.ack)), 32'd1);
            for (int k = 0; k < NREQ; k++) begin
                if (bus.ack[k]) begin
                    ack_log.push_back(k);
                    ack_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [1:0] o, input logic [7:0] d, input logic [7:0] m);
        bus.op[2*i +: 2]        = o;
        bus.wdata[NBITS*i +: NBITS] = d;
        bus.wmask[NBITS*i +: NBITS] = m;
        bus.req[i]              = 1'b1;
    endtask

    // Bounded wait for ack[i]; req[i] is dropped right after the ack cycle is seen.
    task automatic wait_ack(input int i, input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 12 && !seen; n++) begin
            @(negedge C);
            if (bus.ack[i]) seen = 1'b1;
        end
        chk({name, "_ack_seen"}, 32'(seen), 32'd1);
        #1;
        bus.req[i] = 1'b0;
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};
    int n_before;

    initial begin
        bus.req   = '1;
        bus.op    = '0;
        bus.wdata = '0;
        bus.wmask = '0;
        bus.sel   = 1'b0;

        // 1: reset with all requests high, then first grant goes to req0
        @(negedge C);
        @(negedge C);
        chk("t1_rst_Q",    32'(bus.Q),    32'h0);
        chk("t1_rst_ack",  32'(bus.ack),  32'h0);
        chk("t1_rst_busy", 32'(bus.busy), 32'h0);
        #1;
        R = 1'b0;
        ack_log.delete();
        wait_ack(0, "t1");
        bus.req = '0;
        chk("t1_first_grant", 32'(ack_log[0]), 32'd0);

        // 2: single LOAD, then gate Q_out off
        bus.sel = 1'b1;
        set_req(0, 2'b00, 8'hA5, 8'hFF);
        wait_ack(0, "t2");
        chk("t2_Q",     32'(bus.Q),     32'hA5);
        chk("t2_Q_out", 32'(bus.Q_out), 32'hA5);
        bus.sel = 1'b0;
        #1;
        chk("t2_Q_out_gated", 32'(bus.Q_out), 32'h00);

        // 3: clear to zero, masked SET, masked CLEAR
        set_req(3, 2'b10, 8'h00, 8'hFF);
        wait_ack(3, "t3_clr_all");
        chk("t3_Q_zero", 32'(bus.Q), 32'h00);
        set_req(1, 2'b01, 8'h00, 8'h0F);
        wait_ack(1, "t3_set");
        chk("t3_Q_set", 32'(bus.Q), 32'h0F);
        set_req(2, 2'b10, 8'h00, 8'h03);
        wait_ack(2, "t3_clr");
        chk("t3_Q_clr", 32'(bus.Q), 32'h0C);

        // 5a: reserved opcode -> err with ack, bank unchanged (leaves pointer at 0)
        set_req(3, 2'b11, 8'hFF, 8'hFF);
        begin
            bit err_seen;
            err_seen = 1'b0;
            for (int n = 0; n < 12 && !err_seen; n++) begin
                @(negedge C);
                if (bus.ack[3] && bus.err) err_seen = 1'b1;
            end
            chk("t5_err_with_ack", 32'(err_seen), 32'd1);
            #1;
            bus.req[3] = 1'b0;
        end
        chk("t5_rsv_Q", 32'(bus.Q), 32'h0C);

        // 4: all requesting, held -> strict rotation 0,1,2,3,0, one ack per 3 cycles
        for (int i = 0; i < NREQ; i++) set_req(i, 2'b00, 8'hFF, 8'h00);
        ack_log.delete();
        ack_cyc.delete();
        for (int n = 0; n < 40 && ack_log.size() < 5; n++) begin
            @(negedge C);
            #1;
        end
        bus.req = '0;
        chk("t4_ack_count", 32'(ack_log.size()), 32'd5);
        for (int k = 0; k < 5 && k < ack_log.size(); k++)
            chk($sformatf("t4_order_%0d", k), 32'(ack_log[k]), 32'(exp_order[k]));
        for (int k = 1; k < 5 && k < ack_cyc.size(); k++)
            chk($sformatf("t4_spacing_%0d", k), 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd3);

        // 5b: LOAD with empty mask -> ack, no err, bank unchanged
        set_req(1, 2'b00, 8'hFF, 8'h00);
        wait_ack(1, "t5_mask0");
        chk("t5_mask0_err", 32'(bus.err), 32'd0);
        chk("t5_mask0_Q",   32'(bus.Q),   32'h0C);

        // Withdrawal and input change after the grant edge: latched copy completes
        set_req(2, 2'b00, 8'h3C, 8'hFF);
        @(negedge C);
        #1;
        bus.req[2] = 1'b0;
        bus.op[5:4] = 2'b01;
        bus.wdata[23:16] = 8'hFF;
        wait_ack(2, "t_withdraw");
        chk("t_withdraw_Q", 32'(bus.Q), 32'h3C);

        // 6: reset during APPLY -> abandoned, Q cleared, pointer back to 0
        set_req(3, 2'b00, 8'hFF, 8'hFF);
        @(negedge C);
        chk("t6_busy_before_rst", 32'(bus.busy), 32'd1);
        #1;
        R = 1'b1;
        bus.req[3] = 1'b0;
        @(negedge C);
        chk("t6_rst_Q",    32'(bus.Q),    32'h00);
        chk("t6_rst_busy", 32'(bus.busy), 32'd0);
        n_before = ack_log.size();
        #1;
        R = 1'b0;
        repeat (4) @(negedge C);
        chk("t6_no_ack", 32'(ack_log.size() - n_before), 32'd0);
        #1;
        ack_log.delete();
        set_req(0, 2'b01, 8'h00, 8'h81);
        set_req(3, 2'b01, 8'h00, 8'h18);
        wait_ack(0, "t6_req0");
        chk("t6_first_after_rst", 32'(ack_log[0]), 32'd0);
        chk("t6_Q_req0", 32'(bus.Q), 32'h81);
        wait_ack(3, "t6_req3");
        chk("t6_Q_req3", 32'(bus.Q), 32'h99);

        repeat (3) @(negedge C);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
